ram_access_scheduler: RTL

Round-robin scheduler sharing the single-port data RAM between N_REQ bus masters (CPU, DMA, debug/loader port).
Sits between the masters and the RAM.
Owns the request/grant handshake, enforces a one-cycle bus turnaround between owners, and pre-empts a master that holds the bus too long while others wait.
The RAM read-data bus is broadcast to all masters outside this block.

---
 rtl/ucontroller_pkg.sv | 20 ++
 rtl/rr_pick.sv | 38 +++
 rtl/ram_access_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ucontroller_pkg.sv
// Shared definitions for the micro-controller RAM sub-system.
// Holds the scheduler state encoding and the fixed requester indices.
package ucontroller_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OWNED      = 2'd1,
        TURNAROUND = 2'd2
    } sched_state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;
    localparam int REQ_DBG = 2;

    // Round-robin pointer width; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N_REQ. Returns a one-hot winner and a valid flag.
module rr_pick
    import ucontroller_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_valid
);

    localparam logic [PTR_W:0] L_N = (PTR_W+1)'(N_REQ);

    logic [N_REQ-1:0] w_rot;
    logic [PTR_W-1:0] w_off;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_win;

    // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
    assign w_rot   = (i_req >> i_ptr) | (i_req << (L_N - {1'b0, i_ptr}));
    assign o_valid = |i_req;

    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PTR_W'(k);
            end
        end
        w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
        w_win   = (w_sum >= L_N) ? PTR_W'(w_sum - L_N) : PTR_W'(w_sum);
        o_grant = o_valid ? (N_REQ'(1) << w_win) : '0;
    end

endmodule

// File: rtl/ram_access_scheduler.sv
// Round-robin owner of the single-port data RAM with one-cycle turnaround and
// hold-time pre-emption. RAM_SCHED_STATS_EN adds a contention counter.
module ram_access_scheduler
    import ucontroller_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [N_REQ-1:0]        Req,
    output logic [N_REQ-1:0]        Grant,
    input  logic [N_REQ-1:0]        M_Cs,
    input  logic [N_REQ-1:0]        M_Wen,
    input  logic [N_REQ-1:0]        M_Oen,
    input  logic [N_REQ*ADDR_W-1:0] M_Address,
    input  logic [N_REQ*DATA_W-1:0] M_DataOut,
    output logic                    RAM_Cs,
    output logic                    RAM_Wen,
    output logic                    RAM_Oen,
    output logic [ADDR_W-1:0]       RAM_Address,
    output logic [DATA_W-1:0]       RAM_DataIn,
    output logic                    Preempt,
`ifdef RAM_SCHED_STATS_EN
    input  logic                    Stats_Clr,
    output logic [15:0]             Contention_Cnt,
`endif
    output logic                    Sched_Idle
);

    localparam int               PTR_W      = ptr_width(N_REQ);
    localparam logic [7:0]       L_MAX_HOLD = 8'(MAX_HOLD);
    localparam logic [PTR_W-1:0] L_LAST     = PTR_W'(N_REQ - 1);

    sched_state_t      r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_grant, w_grant_nxt, w_pick;
    logic              w_pick_valid;
    logic [PTR_W-1:0]  r_ptr, w_ptr_nxt, w_win_idx;
    logic [7:0]        r_hold, w_hold_nxt;
    logic              r_preempt, w_preempt_nxt;
    logic              r_ram_cs, r_ram_wen, r_ram_oen;
    logic              w_ram_cs_nxt, w_ram_wen_nxt, w_ram_oen_nxt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt, w_sel_addr;
    logic [DATA_W-1:0] r_ram_data, w_ram_data_nxt, w_sel_data;
    logic              w_sel_cs, w_sel_wen, w_sel_oen;
    logic              w_own_req, w_other_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req   (Req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_win_idx  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_win_idx = PTR_W'(i);
            end
            if (r_grant[i]) begin
                w_sel_addr = M_Address[i*ADDR_W +: ADDR_W];
                w_sel_data = M_DataOut[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_cs    = |(M_Cs & r_grant);
    assign w_sel_wen   = ~|(~M_Wen & r_grant);
    assign w_sel_oen   = ~|(~M_Oen & r_grant);
    assign w_own_req   = |(Req & r_grant);
    assign w_other_req = |(Req & ~r_grant);

    // Strobes are only forwarded when ownership continues into the next cycle,
    // so the RAM side is idle on every cycle where Grant is low.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_hold_nxt     = r_hold;
        w_ptr_nxt      = r_ptr;
        w_preempt_nxt  = 1'b0;
        w_ram_cs_nxt   = 1'b0;
        w_ram_wen_nxt  = 1'b1;
        w_ram_oen_nxt  = 1'b1;
        w_ram_addr_nxt = '0;
        w_ram_data_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = OWNED;
                    w_grant_nxt = w_pick;
                    w_hold_nxt  = 8'd1;
                    w_ptr_nxt   = (w_win_idx == L_LAST) ? '0 : w_win_idx + PTR_W'(1);
                end
            end
            OWNED: begin
                if (!w_own_req) begin
                    w_state_nxt = TURNAROUND;
                    w_grant_nxt = '0;
                end else if (r_hold == L_MAX_HOLD && w_other_req) begin
                    w_state_nxt   = TURNAROUND;
                    w_grant_nxt   = '0;
                    w_preempt_nxt = 1'b1;
                end else begin
                    w_hold_nxt     = (r_hold == L_MAX_HOLD) ? r_hold : r_hold + 8'd1;
                    w_ram_cs_nxt   = w_sel_cs;
                    w_ram_wen_nxt  = w_sel_wen;
                    w_ram_oen_nxt  = w_sel_oen;
                    w_ram_addr_nxt = w_sel_addr;
                    w_ram_data_nxt = w_sel_data;
                end
            end
            TURNAROUND: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_hold_nxt  = 8'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_hold_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_hold     <= 8'd0;
            r_ptr      <= '0;
            r_preempt  <= 1'b0;
            r_ram_cs   <= 1'b0;
            r_ram_wen  <= 1'b1;
            r_ram_oen  <= 1'b1;
            r_ram_addr <= '0;
            r_ram_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_hold     <= w_hold_nxt;
            r_ptr      <= w_ptr_nxt;
            r_preempt  <= w_preempt_nxt;
            r_ram_cs   <= w_ram_cs_nxt;
            r_ram_wen  <= w_ram_wen_nxt;
            r_ram_oen  <= w_ram_oen_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_data <= w_ram_data_nxt;
        end
    end

    assign Grant       = r_grant;
    assign Preempt     = r_preempt;
    assign RAM_Cs      = r_ram_cs;
    assign RAM_Wen     = r_ram_wen;
    assign RAM_Oen     = r_ram_oen;
    assign RAM_Address = r_ram_addr;
    assign RAM_DataIn  = r_ram_data;
    assign Sched_Idle  = (r_state == IDLE) && (Req == '0);

`ifdef RAM_SCHED_STATS_EN
    logic [15:0] r_cont_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cont_cnt <= 16'd0;
        end else if (Stats_Clr) begin
            r_cont_cnt <= 16'd0;
        end else if (r_state != IDLE && w_other_req && r_cont_cnt != 16'hFFFF) begin
            r_cont_cnt <= r_cont_cnt + 16'd1;
        end
    end

    assign Contention_Cnt = r_cont_cnt;
`endif

endmodule
